vote_button_conditioner: RTL and testbench

Four-channel front end for the voting machine, sitting directly upstream of the `evm` top-level candidate button inputs. It synchronises raw pushbutton levels, debounces them, and rejects simultaneous presses, so that each voter action yields exactly one clean, one-hot button level. After each accepted vote it enforces a cooldown lockout before the next vote can be taken. Its `clean_button[i]` outputs drive `candidateN_button` (bit 0 drives candidate 1).

---
 rtl/evm_pkg.sv | 38 +++
 rtl/button_sync.sv | 27 ++
 rtl/vote_button_conditioner.sv | 178 +++++++++++++++++
 tb/tb_vote_button_conditioner.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/evm_pkg.sv
// Shared EVM front-end definitions: candidate count, conditioner FSM states
// and combinational helpers on the candidate button vector.
package evm_pkg;

    localparam int NUM_CANDIDATES = 4;
    localparam int IDX_W          = $clog2(NUM_CANDIDATES);
    localparam int ONES_W         = $clog2(NUM_CANDIDATES + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        PRESSED  = 3'd2,
        COOLDOWN = 3'd3,
        RELEASE  = 3'd4
    } vbc_state_t;

    function automatic logic [ONES_W-1:0] count_ones(input logic [NUM_CANDIDATES-1:0] v);
        logic [ONES_W-1:0] n;
        n = {ONES_W{1'b0}};
        for (int i = 0; i < NUM_CANDIDATES; i++) begin
            n = n + {{(ONES_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

    // Lowest set bit; only meaningful when the caller has already proven v one-hot.
    function automatic logic [IDX_W-1:0] onehot_index(input logic [NUM_CANDIDATES-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = NUM_CANDIDATES - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/button_sync.sv
// Multi-bit two-flop synchroniser for independent asynchronous button levels.
module button_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_level,
    output logic [WIDTH-1:0] sync_level
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage capture to resolve metastability on each bit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= async_level;
            sync_r <= meta_r;
        end
    end

    assign sync_level = sync_r;

endmodule

// File: rtl/vote_button_conditioner.sv
// Button front end for the EVM: synchronise, debounce, reject simultaneous
// presses and enforce a cooldown so each voter action yields one clean one-hot level.
module vote_button_conditioner
    import evm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int COOLDOWN_CYCLES = 32,
    parameter int CNT_W = $clog2(((DEBOUNCE_CYCLES > COOLDOWN_CYCLES) ?
                                   DEBOUNCE_CYCLES : COOLDOWN_CYCLES) + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_CANDIDATES-1:0] raw_button,
    output logic [NUM_CANDIDATES-1:0] clean_button,
    output logic                      vote_accepted,
    output logic                      multi_reject,
    output logic                      busy
);

    localparam logic [CNT_W-1:0]          DEB_LIMIT  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]          COOL_LIMIT = CNT_W'(COOLDOWN_CYCLES);
    localparam logic [CNT_W-1:0]          CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]          CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]          CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [ONES_W-1:0]         MULTI_MIN  = ONES_W'(2);
    localparam logic [NUM_CANDIDATES-1:0] NO_BUTTON  = {NUM_CANDIDATES{1'b0}};

    logic [NUM_CANDIDATES-1:0] sync_s;
    logic [NUM_CANDIDATES-1:0] idx_mask_s;
    logic [CNT_W-1:0]          cnt_inc_s;

    vbc_state_t                state_r;
    vbc_state_t                state_nxt_s;
    logic [CNT_W-1:0]          cnt_r;
    logic [CNT_W-1:0]          cnt_nxt_s;
    logic [IDX_W-1:0]          idx_r;
    logic [IDX_W-1:0]          idx_nxt_s;
    logic [NUM_CANDIDATES-1:0] clean_r;
    logic [NUM_CANDIDATES-1:0] clean_nxt_s;
    logic                      vote_r;
    logic                      vote_nxt_s;
    logic                      multi_r;
    logic                      multi_nxt_s;
    logic                      busy_r;

    button_sync #(
        .WIDTH (NUM_CANDIDATES)
    ) u_button_sync (
        .clock       (clock),
        .reset       (reset),
        .async_level (raw_button),
        .sync_level  (sync_s)
    );

    assign idx_mask_s = {{(NUM_CANDIDATES-1){1'b0}}, 1'b1} << idx_r;
    assign cnt_inc_s  = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);

    // Next-state, counter and output decisions; a count transitions only once it already sits at its limit.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        idx_nxt_s   = idx_r;
        clean_nxt_s = clean_r;
        vote_nxt_s  = 1'b0;
        multi_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (sync_s == NO_BUTTON) begin
                    state_nxt_s = IDLE;
                end else if (count_ones(sync_s) >= MULTI_MIN) begin
                    multi_nxt_s = 1'b1;
                    state_nxt_s = RELEASE;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (enable) begin
                    state_nxt_s = DEBOUNCE;
                    idx_nxt_s   = onehot_index(sync_s);
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DEBOUNCE: begin
                if (!enable) begin
                    state_nxt_s = RELEASE;
                    cnt_nxt_s   = CNT_ZERO;
                    clean_nxt_s = NO_BUTTON;
                end else if (sync_s == idx_mask_s) begin
                    if (cnt_r >= DEB_LIMIT) begin
                        state_nxt_s = PRESSED;
                        cnt_nxt_s   = CNT_ZERO;
                        clean_nxt_s = idx_mask_s;
                        vote_nxt_s  = 1'b1;
                    end else begin
                        cnt_nxt_s   = cnt_inc_s;
                    end
                end else if (sync_s == NO_BUTTON) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    multi_nxt_s = 1'b1;
                    state_nxt_s = RELEASE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            PRESSED: begin
                if (!enable) begin
                    state_nxt_s = RELEASE;
                    cnt_nxt_s   = CNT_ZERO;
                    clean_nxt_s = NO_BUTTON;
                end else if (sync_s[idx_r]) begin
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r >= DEB_LIMIT) begin
                    state_nxt_s = COOLDOWN;
                    cnt_nxt_s   = CNT_ZERO;
                    clean_nxt_s = NO_BUTTON;
                end else begin
                    cnt_nxt_s   = cnt_inc_s;
                end
            end
            COOLDOWN: begin
                if (!enable) begin
                    state_nxt_s = RELEASE;
                    cnt_nxt_s   = CNT_ZERO;
                    clean_nxt_s = NO_BUTTON;
                end else if (cnt_r >= COOL_LIMIT) begin
                    state_nxt_s = RELEASE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s   = cnt_inc_s;
                end
            end
            RELEASE: begin
                // A button still held after cooldown keeps us here until it is let go.
                if (sync_s != NO_BUTTON) begin
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r >= DEB_LIMIT) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s   = cnt_inc_s;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = CNT_ZERO;
                clean_nxt_s = NO_BUTTON;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            idx_r   <= {IDX_W{1'b0}};
            clean_r <= NO_BUTTON;
            vote_r  <= 1'b0;
            multi_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            idx_r   <= idx_nxt_s;
            clean_r <= clean_nxt_s;
            vote_r  <= vote_nxt_s;
            multi_r <= multi_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
        end
    end

    assign clean_button  = clean_r;
    assign vote_accepted = vote_r;
    assign multi_reject  = multi_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_vote_button_conditioner.sv
// Self-checking bench for vote_button_conditioner with a timestamp-based reference model.
module tb_vote_button_conditioner;

    localparam int D = 4;
    localparam int C = 3;

    logic       clock      = 1'b0;
    logic       reset      = 1'b0;
    logic       enable     = 1'b0;
    logic [3:0] raw_button = 4'b0000;
    logic [3:0] clean_button;
    logic       vote_accepted;
    logic       multi_reject;
    logic       busy;
    logic [6:0] dut_out;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase name, edge timestamps and the two synchroniser stages.
    string      phase  = "idle";
    int         edge_no = 0;
    int         t0      = 0;
    int         ref_t   = 0;
    logic [3:0] m_meta  = 4'b0000;
    logic [3:0] m_sync  = 4'b0000;
    logic [3:0] m_mask  = 4'b0000;
    logic [3:0] m_clean = 4'b0000;
    logic       m_vote  = 1'b0;
    logic       m_multi = 1'b0;

    vote_button_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .COOLDOWN_CYCLES (C)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .raw_button    (raw_button),
        .clean_button  (clean_button),
        .vote_accepted (vote_accepted),
        .multi_reject  (multi_reject),
        .busy          (busy)
    );

    assign dut_out = {clean_button, vote_accepted, multi_reject, busy};

    always #5 clock = ~clock;

    function automatic logic [6:0] exp_out();
        return {m_clean, m_vote, m_multi, (phase != "idle")};
    endfunction

    task automatic model_reset();
        phase   = "idle";
        m_meta  = 4'b0000;
        m_sync  = 4'b0000;
        m_mask  = 4'b0000;
        m_clean = 4'b0000;
        m_vote  = 1'b0;
        m_multi = 1'b0;
    endtask

    // One rising edge of the reference: s is the raw level from two edges ago.
    task automatic model_step();
        int         t;
        logic [3:0] s;
        if (reset === 1'b0) begin
            model_reset();
        end else begin
            t       = edge_no;
            edge_no = edge_no + 1;
            s       = m_sync;
            m_vote  = 1'b0;
            m_multi = 1'b0;
            if (phase != "idle" && phase != "release" && !enable) begin
                phase = "release"; ref_t = t; m_clean = 4'b0000;
            end else if (phase == "idle") begin
                if (s == 4'b0000) begin
                    phase = "idle";
                end else if ($countones(s) >= 2) begin
                    m_multi = 1'b1; phase = "release"; ref_t = t;
                end else if (enable) begin
                    phase = "debounce"; t0 = t; m_mask = s;
                end
            end else if (phase == "debounce") begin
                if (s == m_mask) begin
                    if (t - t0 >= D) begin
                        phase = "pressed"; ref_t = t; m_clean = m_mask; m_vote = 1'b1;
                    end
                end else if (s == 4'b0000) begin
                    phase = "idle";
                end else begin
                    m_multi = 1'b1; phase = "release"; ref_t = t;
                end
            end else if (phase == "pressed") begin
                if ((s & m_mask) != 4'b0000) ref_t = t;
                else if (t - ref_t >= D + 1) begin
                    phase = "cooldown"; t0 = t; m_clean = 4'b0000;
                end
            end else if (phase == "cooldown") begin
                if (t - t0 >= C + 1) begin
                    phase = "release"; ref_t = t;
                end
            end else begin
                if (s != 4'b0000) ref_t = t;
                else if (t - ref_t >= D + 1) phase = "idle";
            end
            m_sync = m_meta;
            m_meta = raw_button;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b1; raw_button = 4'b0110;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (dut_out !== 7'b0000000) begin
                n_errors++;
                $display("FAIL reset_state cycle %0d: got %b expected %b", k, dut_out, 7'b0000000);
            end
        end
        raw_button = 4'b0000;
        #3 reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (dut_out !== exp_out()) begin
                n_errors++;
                $display("FAIL reset_release cycle %0d: got %b expected %b", k, dut_out, exp_out());
            end
        end
    endtask

    task automatic test_clean_press();
        int votes = 0;
        for (int k = 0; k <= 40; k++) begin
            raw_button = (k < 20) ? 4'b0010 : 4'b0000;
            tick();
            n_checks++;
            if (dut_out !== exp_out()) begin
                n_errors++;
                $display("FAIL clean_press cycle %0d: got %b expected %b", k, dut_out, exp_out());
            end
            if (vote_accepted === 1'b1) votes++;
            if (k == 5 || k == 26) begin
                n_checks++;
                if (clean_button !== 4'b0000) begin
                    n_errors++;
                    $display("FAIL press_edge_low cycle %0d: got %b expected 0000", k, clean_button);
                end
            end
            if (k == 6) begin
                n_checks++;
                if ({clean_button, vote_accepted, busy} !== 6'b0010_1_1) begin
                    n_errors++;
                    $display("FAIL press_rise cycle %0d: got %b expected 001011", k, {clean_button, vote_accepted, busy});
                end
            end
            if (k == 25) begin
                n_checks++;
                if (clean_button !== 4'b0010) begin
                    n_errors++;
                    $display("FAIL release_hold cycle %0d: got %b expected 0010", k, clean_button);
                end
            end
        end
        n_checks++;
        if (votes != 1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL press_summary: got votes=%0d busy=%b expected votes=1 busy=0", votes, busy);
        end
    endtask

    task automatic test_bounce();
        int pairs = $urandom_range(2, 4);
        int votes = 0;
        for (int j = 0; j < 2 * pairs; j++) begin
            raw_button = (j % 2 == 0) ? 4'b0001 : 4'b0000;
            tick();
            n_checks++;
            if (dut_out !== exp_out() || clean_button !== 4'b0000 || vote_accepted !== 1'b0) begin
                n_errors++;
                $display("FAIL bounce_quiet step %0d: got %b expected %b", j, dut_out, exp_out());
            end
        end
        for (int k = 0; k <= 32; k++) begin
            raw_button = (k < 15) ? 4'b0001 : 4'b0000;
            tick();
            n_checks++;
            if (dut_out !== exp_out()) begin
                n_errors++;
                $display("FAIL bounce cycle %0d: got %b expected %b", k, dut_out, exp_out());
            end
            if (vote_accepted === 1'b1) votes++;
            if (k == 5 || k == 6) begin
                n_checks++;
                if (clean_button !== ((k == 6) ? 4'b0001 : 4'b0000)) begin
                    n_errors++;
                    $display("FAIL bounce_edge cycle %0d: got %b", k, clean_button);
                end
            end
        end
        n_checks++;
        if (votes != 1) begin
            n_errors++;
            $display("FAIL bounce_votes: got %0d expected 1", votes);
        end
    endtask

    task automatic test_simultaneous();
        int rejects = 0;
        for (int k = 0; k <= 16; k++) begin
            raw_button = (k < 6) ? 4'b0101 : 4'b0000;
            tick();
            n_checks++;
            if (dut_out !== exp_out() || clean_button !== 4'b0000) begin
                n_errors++;
                $display("FAIL simultaneous cycle %0d: got %b expected %b", k, dut_out, exp_out());
            end
            if (multi_reject === 1'b1) rejects++;
            if (k == 2) begin
                n_checks++;
                if (multi_reject !== 1'b1) begin
                    n_errors++;
                    $display("FAIL multi_pulse cycle %0d: got %b expected 1", k, multi_reject);
                end
            end
        end
        n_checks++;
        if (rejects != 1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL multi_summary: got rejects=%0d busy=%b expected 1 and 0", rejects, busy);
        end
    endtask

    task automatic test_held_cooldown();
        int votes = 0;
        for (int k = 0; k <= 78; k++) begin
            if (k < 10)      raw_button = 4'b1000;
            else if (k < 16) raw_button = 4'b0000;
            else if (k < 36) raw_button = 4'b1000;
            else if (k < 46) raw_button = 4'b0000;
            else if (k < 60) raw_button = 4'b1000;
            else             raw_button = 4'b0000;
            tick();
            n_checks++;
            if (dut_out !== exp_out()) begin
                n_errors++;
                $display("FAIL held_cooldown cycle %0d: got %b expected %b", k, dut_out, exp_out());
            end
            if (vote_accepted === 1'b1) votes++;
            if (k == 51 || k == 52) begin
                n_checks++;
                if (votes != k - 50) begin
                    n_errors++;
                    $display("FAIL revote_gate cycle %0d: got votes=%0d expected %0d", k, votes, k - 50);
                end
            end
        end
        n_checks++;
        if (votes != 2 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL held_summary: got votes=%0d busy=%b expected 2 and 0", votes, busy);
        end
    endtask

    task automatic test_enable_drop();
        int pulses = 0;
        for (int k = 0; k <= 30; k++) begin
            raw_button = (k < 15) ? 4'b1000 : 4'b0000;
            enable     = (k >= 9 && k < 22) ? 1'b0 : 1'b1;
            tick();
            n_checks++;
            if (dut_out !== exp_out()) begin
                n_errors++;
                $display("FAIL enable_drop cycle %0d: got %b expected %b", k, dut_out, exp_out());
            end
            if (k > 6 && (vote_accepted === 1'b1 || multi_reject === 1'b1)) pulses++;
            if (k == 8 || k == 9) begin
                n_checks++;
                if (clean_button !== ((k == 8) ? 4'b1000 : 4'b0000)) begin
                    n_errors++;
                    $display("FAIL enable_clear cycle %0d: got %b", k, clean_button);
                end
            end
            if (k == 20 || k == 21) begin
                n_checks++;
                if (busy !== (k == 20)) begin
                    n_errors++;
                    $display("FAIL enable_idle cycle %0d: got busy=%b", k, busy);
                end
            end
        end
        enable = 1'b1;
        n_checks++;
        if (pulses != 0) begin
            n_errors++;
            $display("FAIL enable_pulses: got %0d expected 0", pulses);
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k <= 40; k++) begin
            raw_button = (k < 21) ? 4'b0100 : 4'b0000;
            tick();
            n_checks++;
            if (dut_out !== exp_out()) begin
                n_errors++;
                $display("FAIL async_reset cycle %0d: got %b expected %b", k, dut_out, exp_out());
            end
            if (k == 8) begin
                n_checks++;
                if (clean_button !== 4'b0100) begin
                    n_errors++;
                    $display("FAIL pre_reset_press: got %b expected 0100", clean_button);
                end
                #3 reset = 1'b0;
                #1;
                n_checks++;
                if (dut_out !== 7'b0000000) begin
                    n_errors++;
                    $display("FAIL reset_immediate: got %b expected %b", dut_out, 7'b0000000);
                end
                model_reset();
            end
            if (k == 10) #3 reset = 1'b1;
            if (k == 16 || k == 17) begin
                n_checks++;
                if ({clean_button, vote_accepted} !== ((k == 17) ? 5'b0100_1 : 5'b0000_0)) begin
                    n_errors++;
                    $display("FAIL post_reset_press cycle %0d: got %b", k, {clean_button, vote_accepted});
                end
            end
        end
    endtask

    task automatic test_random_soak();
        int hold = 0;
        int en_hold = 0;
        int r;
        for (int k = 0; k < 500; k++) begin
            if (hold == 0) begin
                r = $urandom_range(0, 9);
                if (r < 4)      raw_button = 4'b0000;
                else if (r < 8) raw_button = 4'b0001 << $urandom_range(0, 3);
                else            raw_button = 4'($urandom_range(0, 15));
                hold = $urandom_range(1, 14);
            end else begin
                hold--;
            end
            if (en_hold == 0) begin
                enable  = ($urandom_range(0, 7) != 0);
                en_hold = $urandom_range(1, 25);
            end else begin
                en_hold--;
            end
            if (k >= 460) begin
                raw_button = 4'b0000;
                enable     = 1'b1;
            end
            tick();
            n_checks++;
            if (dut_out !== exp_out() || $countones(clean_button) > 1 || (vote_accepted & multi_reject)) begin
                n_errors++;
                $display("FAIL random cycle %0d: got %b expected %b", k, dut_out, exp_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_held_cooldown();
        test_enable_drop();
        test_async_reset();
        test_random_soak();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
